// File: rtl/word_pkg.sv
// Shared constants and state encoding for the word entry sequencer.
package word_pkg;

    localparam int unsigned DEF_NUM_LETTERS = 10;
    localparam int unsigned DEF_IDX_W       = 4;

    localparam logic [7:0] KEY_LEFT  = 8'h12;
    localparam logic [7:0] KEY_RIGHT = 8'h14;
    localparam logic [7:0] KEY_ENTER = 8'h0A;
    localparam logic [7:0] PRINT_LO  = 8'h20;
    localparam logic [7:0] PRINT_HI  = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SEND
    } state_t;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= PRINT_LO) && (code <= PRINT_HI);
    endfunction

endpackage

// File: rtl/word_entry_ctrl_if.sv
// Key, buffer and playback signals between the controller and its neighbours.
interface word_entry_ctrl_if #(
    parameter int unsigned IDX_W = word_pkg::DEF_IDX_W
);
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ready;
    logic [IDX_W-1:0] cursor;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [7:0]       wr_data;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [7:0]       rd_data;
    logic             word_valid;
    logic             word_ready;
    logic [7:0]       word_letter;
    logic [IDX_W-1:0] word_index;
    logic             word_last;
    logic             busy;
    logic             done;

    modport master (
        input  key_valid, key_code, rd_data, word_ready,
        output key_ready, cursor, wr_en, wr_addr, wr_data, rd_en, rd_addr,
               word_valid, word_letter, word_index, word_last, busy, done
    );

    modport slave (
        output key_valid, key_code, rd_data, word_ready,
        input  key_ready, cursor, wr_en, wr_addr, wr_data, rd_en, rd_addr,
               word_valid, word_letter, word_index, word_last, busy, done
    );
endinterface

// File: rtl/word_entry_ctrl.sv
// Turns key events into cursor moves / buffer writes, and on Enter plays the
// stored word back one letter at a time (FETCH -> CAPTURE -> SEND per letter).
module word_entry_ctrl
    import word_pkg::*;
#(
    parameter int unsigned NUM_LETTERS = DEF_NUM_LETTERS,
    parameter int unsigned IDX_W       = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    word_entry_ctrl_if.master  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LETTERS - 1);

    state_t           state_q;
    logic             key_ready_q;
    logic [IDX_W-1:0] cursor_q;
    logic [IDX_W-1:0] index_q;
    logic             wr_en_q;
    logic [IDX_W-1:0] wr_addr_q;
    logic [7:0]       wr_data_q;
    logic             rd_en_q;
    logic [IDX_W-1:0] rd_addr_q;
    logic             word_valid_q;
    logic [7:0]       word_letter_q;
    logic [IDX_W-1:0] word_index_q;
    logic             word_last_q;
    logic             busy_q;
    logic             done_q;

    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (v == LAST_IDX) ? v : v + IDX_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            key_ready_q   <= 1'b1;
            cursor_q      <= '0;
            index_q       <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            word_valid_q  <= 1'b0;
            word_letter_q <= '0;
            word_index_q  <= '0;
            word_last_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.key_valid && key_ready_q) begin
                        if (bus.key_code == KEY_LEFT) begin
                            if (cursor_q != '0) cursor_q <= cursor_q - IDX_W'(1);
                        end else if (bus.key_code == KEY_RIGHT) begin
                            cursor_q <= sat_inc(cursor_q);
                        end else if (bus.key_code == KEY_ENTER) begin
                            index_q     <= '0;
                            rd_addr_q   <= '0;
                            rd_en_q     <= 1'b1;
                            key_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= FETCH;
                        end else if (is_printable(bus.key_code)) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= cursor_q;
                            wr_data_q <= bus.key_code;
                            cursor_q  <= sat_inc(cursor_q);
                        end
                    end
                end
                // Buffer read port answers one cycle after rd_en.
                FETCH: state_q <= CAPTURE;
                CAPTURE: begin
                    word_letter_q <= bus.rd_data;
                    word_index_q  <= index_q;
                    word_last_q   <= (index_q == LAST_IDX);
                    word_valid_q  <= 1'b1;
                    state_q       <= SEND;
                end
                SEND: begin
                    if (bus.word_ready) begin
                        word_valid_q <= 1'b0;
                        if (word_last_q) begin
                            done_q      <= 1'b1;
                            key_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            cursor_q    <= '0;
                            state_q     <= IDLE;
                        end else begin
                            index_q   <= sat_inc(index_q);
                            rd_addr_q <= sat_inc(index_q);
                            rd_en_q   <= 1'b1;
                            state_q   <= FETCH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.key_ready   = key_ready_q;
    assign bus.cursor      = cursor_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.word_valid  = word_valid_q;
    assign bus.word_letter = word_letter_q;
    assign bus.word_index  = word_index_q;
    assign bus.word_last   = word_last_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_word_entry_ctrl.sv
// Directed bench for word_entry_ctrl; the bench itself acts as the 10-letter buffer.
module tb_word_entry_ctrl;
    import word_pkg::*;

    localparam int unsigned NL = 10;
    localparam int unsigned IW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    word_entry_ctrl_if #(.IDX_W(IW)) bus();

    word_entry_ctrl #(.NUM_LETTERS(NL), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Buffer: one write port, registered read port
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_w [NL];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs playback from the cycle after Enter acceptance until done; scoreboards letters.
    task automatic play(input bit stall, input string tag);
        int got = 0;
        bit pv = 1'b0;
        bit pr = 1'b0;
        logic [7:0] pl = '0;
        logic [IW-1:0] pi = '0;
        bit fin = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (pv && !pr) begin
                chk({tag, " hold_valid"}, 32'(bus.word_valid), 32'(1));
                chk({tag, " hold_letter"}, 32'(bus.word_letter), 32'(pl));
                chk({tag, " hold_index"}, 32'(bus.word_index), 32'(pi));
            end
            if (bus.done) begin
                chk({tag, " letters"}, 32'(got), 32'(NL));
                chk({tag, " done_cursor"}, 32'(bus.cursor), 32'(0));
                chk({tag, " done_key_ready"}, 32'(bus.key_ready), 32'(1));
                chk({tag, " done_busy"}, 32'(bus.busy), 32'(0));
                fin = 1'b1;
            end else begin
                chk({tag, " key_ready_low"}, 32'(bus.key_ready), 32'(0));
                chk({tag, " no_write"}, 32'(bus.wr_en), 32'(0));
                bus.word_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.word_valid && bus.word_ready) begin
                    if (got < int'(NL)) begin
                        chk({tag, " letter"}, 32'(bus.word_letter), 32'(exp_w[got]));
                        chk({tag, " index"}, 32'(bus.word_index), 32'(got));
                        chk({tag, " last"}, 32'(bus.word_last), 32'(got == int'(NL) - 1));
                    end else begin
                        chk({tag, " extra_letter"}, 32'(got), 32'(NL - 1));
                    end
                    got++;
                end
                pv = bus.word_valid;
                pr = bus.word_ready;
                pl = bus.word_letter;
                pi = bus.word_index;
                step();
            end
        end
        if (!fin) chk({tag, " timeout"}, 32'(0), 32'(1));
    endtask

    initial begin
        string s;
        bit hit;
        reset          = 1'b1;
        bus.key_valid  = 1'b0;
        bus.key_code   = 8'h00;
        bus.word_ready = 1'b0;
        repeat (2) step();
        chk("rst cursor", 32'(bus.cursor), 32'(0));
        chk("rst wr_en", 32'(bus.wr_en), 32'(0));
        chk("rst busy", 32'(bus.busy), 32'(0));
        chk("rst word_valid", 32'(bus.word_valid), 32'(0));
        reset = 1'b0;
        step();
        chk("post_rst key_ready", 32'(bus.key_ready), 32'(1));
        chk("post_rst rd_en", 32'(bus.rd_en), 32'(0));
        chk("post_rst done", 32'(bus.done), 32'(0));

        // Three printable keys back-to-back
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h41;
        step();
        chk("A wr_en", 32'(bus.wr_en), 32'(1));
        chk("A wr_addr", 32'(bus.wr_addr), 32'(0));
        chk("A wr_data", 32'(bus.wr_data), 32'h41);
        chk("A cursor", 32'(bus.cursor), 32'(1));
        bus.key_code = 8'h42;
        step();
        chk("B wr_en", 32'(bus.wr_en), 32'(1));
        chk("B wr_addr", 32'(bus.wr_addr), 32'(1));
        chk("B wr_data", 32'(bus.wr_data), 32'h42);
        bus.key_code = 8'h43;
        step();
        chk("C wr_en", 32'(bus.wr_en), 32'(1));
        chk("C wr_addr", 32'(bus.wr_addr), 32'(2));
        chk("C wr_data", 32'(bus.wr_data), 32'h43);
        chk("C cursor", 32'(bus.cursor), 32'(3));

        // Cursor saturation both ways
        bus.key_code = KEY_LEFT;
        repeat (2) step();
        chk("left to 1", 32'(bus.cursor), 32'(1));
        repeat (3) step();
        chk("left sat 0", 32'(bus.cursor), 32'(0));
        chk("left no write", 32'(bus.wr_en), 32'(0));
        bus.key_code = KEY_RIGHT;
        repeat (12) step();
        chk("right sat 9", 32'(bus.cursor), 32'(9));
        bus.key_code = 8'h5A;
        step();
        chk("Z wr_en", 32'(bus.wr_en), 32'(1));
        chk("Z wr_addr", 32'(bus.wr_addr), 32'(9));
        chk("Z wr_data", 32'(bus.wr_data), 32'h5A);
        chk("Z cursor", 32'(bus.cursor), 32'(9));

        // Non-printable, non-command key is consumed and ignored
        bus.key_code = 8'h07;
        chk("bel key_ready", 32'(bus.key_ready), 32'(1));
        step();
        chk("bel wr_en", 32'(bus.wr_en), 32'(0));
        chk("bel cursor", 32'(bus.cursor), 32'(9));

        // Type HELLOWORLD from position 0
        s = "HELLOWORLD";
        for (int i = 0; i < int'(NL); i++) exp_w[i] = s[i];
        bus.key_code = KEY_LEFT;
        repeat (10) step();
        chk("home cursor", 32'(bus.cursor), 32'(0));
        for (int i = 0; i < int'(NL); i++) begin
            bus.key_code = exp_w[i];
            step();
        end
        bus.key_valid = 1'b0;
        chk("D wr_addr", 32'(bus.wr_addr), 32'(9));
        chk("D wr_data", 32'(bus.wr_data), 32'h44);
        chk("typed cursor", 32'(bus.cursor), 32'(9));
        step();

        // Full-rate playback, cycle-exact
        bus.word_ready = 1'b1;
        bus.key_valid  = 1'b1;
        bus.key_code   = KEY_ENTER;
        step();
        bus.key_valid = 1'b0;
        chk("enter busy", 32'(bus.busy), 32'(1));
        chk("enter rd_en", 32'(bus.rd_en), 32'(1));
        chk("enter rd_addr", 32'(bus.rd_addr), 32'(0));
        chk("enter key_ready", 32'(bus.key_ready), 32'(0));
        for (int c = 1; c <= 31; c++) begin
            chk($sformatf("pb valid c%0d", c), 32'(bus.word_valid), 32'((c % 3 == 0) && (c <= 30)));
            chk($sformatf("pb done c%0d", c), 32'(bus.done), 32'(c == 31));
            if (bus.word_valid) begin
                chk($sformatf("pb letter c%0d", c), 32'(bus.word_letter), 32'(exp_w[c / 3 - 1]));
                chk($sformatf("pb index c%0d", c), 32'(bus.word_index), 32'(c / 3 - 1));
                chk($sformatf("pb last c%0d", c), 32'(bus.word_last), 32'(c == 30));
            end
            if (c < 31) step();
        end
        chk("pb cursor", 32'(bus.cursor), 32'(0));
        chk("pb key_ready", 32'(bus.key_ready), 32'(1));
        chk("pb busy", 32'(bus.busy), 32'(0));
        step();
        chk("pb done one cycle", 32'(bus.done), 32'(0));

        // Stalled playback with a key held pending
        bus.key_valid = 1'b1;
        bus.key_code  = KEY_ENTER;
        step();
        bus.key_code = 8'h51;
        play(1'b1, "stall");
        step();
        bus.key_valid = 1'b0;
        chk("held key wr_en", 32'(bus.wr_en), 32'(1));
        chk("held key wr_addr", 32'(bus.wr_addr), 32'(0));
        chk("held key wr_data", 32'(bus.wr_data), 32'h51);
        chk("held key cursor", 32'(bus.cursor), 32'(1));
        exp_w[0] = 8'h51;
        step();

        // Reset while SEND at index 4
        bus.word_ready = 1'b1;
        bus.key_valid  = 1'b1;
        bus.key_code   = KEY_ENTER;
        step();
        bus.key_valid = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (bus.word_valid && bus.word_index == IW'(4)) hit = 1'b1;
            else step();
        end
        chk("reach index4", 32'(hit), 32'(1));
        bus.word_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst busy", 32'(bus.busy), 32'(0));
        chk("mid_rst word_valid", 32'(bus.word_valid), 32'(0));
        chk("mid_rst word_index", 32'(bus.word_index), 32'(0));
        chk("mid_rst word_letter", 32'(bus.word_letter), 32'(0));
        chk("mid_rst word_last", 32'(bus.word_last), 32'(0));
        chk("mid_rst rd_en", 32'(bus.rd_en), 32'(0));
        chk("mid_rst rd_addr", 32'(bus.rd_addr), 32'(0));
        chk("mid_rst wr_addr", 32'(bus.wr_addr), 32'(0));
        chk("mid_rst wr_data", 32'(bus.wr_data), 32'(0));
        chk("mid_rst cursor", 32'(bus.cursor), 32'(0));
        chk("mid_rst done", 32'(bus.done), 32'(0));
        step();
        reset = 1'b0;
        step();
        chk("post_mid_rst done", 32'(bus.done), 32'(0));
        chk("post_mid_rst key_ready", 32'(bus.key_ready), 32'(1));
        bus.key_valid = 1'b1;
        bus.key_code  = KEY_ENTER;
        step();
        bus.key_valid = 1'b0;
        chk("replay rd_addr", 32'(bus.rd_addr), 32'(0));
        play(1'b0, "replay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
